// File: rtl/alu_pkg.sv
// ALU shared definitions: data width and 4-bit opcode encoding.
package alu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_SLTU = 4'b1001
  } alu_op_e;

endpackage

// File: rtl/alu_shifter.sv
// Barrel shifter: left, logical right or arithmetic right by 0..31.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] value,
  input  logic [4:0]      amount,
  input  logic            dir,
  input  logic            arith,
  output logic [XLEN-1:0] shifted
);

  logic            fill;
  logic [XLEN:0]   ext;
  logic [XLEN:0]   ext_sh;

  always_comb begin
    fill   = arith & value[XLEN-1];
    ext    = {fill, value};
    ext_sh = $unsigned($signed(ext) >>> amount);
    if (dir) begin
      shifted = ext_sh[XLEN-1:0];
    end else begin
      shifted = value << amount;
    end
  end

endmodule

// File: rtl/alu_unit.sv
// 32-bit integer ALU with combinational and registered outputs.
// Define ALU_FLAGS_EN to add carry/overflow/negative status flags.
module alu_unit
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [3:0]      alu_op,
  input  logic            en,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal_op,
  output logic [XLEN-1:0] result_q,
  output logic            zero_q,
  output logic            illegal_q
`ifdef ALU_FLAGS_EN
  ,
  output logic            carry,
  output logic            overflow,
  output logic            negative,
  output logic            carry_q,
  output logic            overflow_q,
  output logic            negative_q
`endif
);

  logic is_add, is_sub, is_and, is_or, is_xor;
  logic is_sll, is_srl, is_sra, is_slt, is_sltu;

  logic [XLEN-1:0] add_res;
  logic [XLEN-1:0] sub_res;
  logic [XLEN-1:0] sh_res;
  logic            sh_dir;
  logic            sh_arith;

  logic [XLEN-1:0] result_d;
  logic            zero_d;
  logic            illegal_d;

  always_comb begin
    is_add  = (alu_op == OP_ADD);
    is_sub  = (alu_op == OP_SUB);
    is_and  = (alu_op == OP_AND);
    is_or   = (alu_op == OP_OR);
    is_xor  = (alu_op == OP_XOR);
    is_sll  = (alu_op == OP_SLL);
    is_srl  = (alu_op == OP_SRL);
    is_sra  = (alu_op == OP_SRA);
    is_slt  = (alu_op == OP_SLT);
    is_sltu = (alu_op == OP_SLTU);
  end

`ifdef ALU_FLAGS_EN
  logic [XLEN:0] add_w;
  logic [XLEN:0] sub_w;

  // Subtract as a + ~b + 1 so bit XLEN is the inverted borrow.
  always_comb begin
    add_w   = {1'b0, src_a} + {1'b0, src_b};
    sub_w   = {1'b0, src_a} + {1'b0, ~src_b} + {{XLEN{1'b0}}, 1'b1};
    add_res = add_w[XLEN-1:0];
    sub_res = sub_w[XLEN-1:0];
  end
`else
  always_comb begin
    add_res = src_a + src_b;
    sub_res = src_a - src_b;
  end
`endif

  assign sh_dir   = is_srl | is_sra;
  assign sh_arith = is_sra;

  alu_shifter u_shifter (
    .value   (src_a),
    .amount  (src_b[4:0]),
    .dir     (sh_dir),
    .arith   (sh_arith),
    .shifted (sh_res)
  );

  always_comb begin
    result     = '0;
    illegal_op = 1'b0;
    unique case (1'b1)
      is_add:  result = add_res;
      is_sub:  result = sub_res;
      is_and:  result = src_a & src_b;
      is_or:   result = src_a | src_b;
      is_xor:  result = src_a ^ src_b;
      is_sll,
      is_srl,
      is_sra:  result = sh_res;
      is_slt:  result = {{(XLEN-1){1'b0}},
                         $signed(src_a) < $signed(src_b)};
      is_sltu: result = {{(XLEN-1){1'b0}}, src_a < src_b};
      default: illegal_op = 1'b1;
    endcase
    zero = (result == '0);
  end

  always_comb begin
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (en) begin
      result_d  = result;
      zero_d    = zero;
      illegal_d = illegal_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ALU_FLAGS_EN
  logic carry_d;
  logic overflow_d;
  logic negative_d;

  always_comb begin
    carry    = 1'b0;
    overflow = 1'b0;
    if (is_add) begin
      carry    = add_w[XLEN];
      overflow = (src_a[XLEN-1] == src_b[XLEN-1]) &&
                 (add_res[XLEN-1] != src_a[XLEN-1]);
    end else if (is_sub) begin
      carry    = sub_w[XLEN];
      overflow = (src_a[XLEN-1] != src_b[XLEN-1]) &&
                 (sub_res[XLEN-1] != src_a[XLEN-1]);
    end
    negative = result[XLEN-1];
  end

  always_comb begin
    carry_d    = carry_q;
    overflow_d = overflow_q;
    negative_d = negative_q;
    if (en) begin
      carry_d    = carry;
      overflow_d = overflow;
      negative_d = negative;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      negative_q <= 1'b0;
    end else begin
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      negative_q <= negative_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_unit.sv
// Random + directed self-checking bench for alu_unit against a
// behavioural arithmetic model and a registered-output scoreboard.
module tb_alu_unit;

  logic        clk;
  logic        rst;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  alu_op;
  logic        en;
  logic [31:0] result;
  logic        zero;
  logic        illegal_op;
  logic [31:0] result_q;
  logic        zero_q;
  logic        illegal_q;
`ifdef ALU_FLAGS_EN
  logic carry, overflow, negative;
  logic carry_q, overflow_q, negative_q;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic chk_on = 1'b0;

  alu_unit dut (
    .clk        (clk),
    .rst        (rst),
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_op     (alu_op),
    .en         (en),
    .result     (result),
    .zero       (zero),
    .illegal_op (illegal_op),
    .result_q   (result_q),
    .zero_q     (zero_q),
    .illegal_q  (illegal_q)
`ifdef ALU_FLAGS_EN
    ,
    .carry      (carry),
    .overflow   (overflow),
    .negative   (negative),
    .carry_q    (carry_q),
    .overflow_q (overflow_q),
    .negative_q (negative_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arithmetic straight from the opcode definitions.
  function automatic logic [31:0] m_res(logic [3:0] op,
                                        logic [31:0] a,
                                        logic [31:0] b);
    longint sa, sb;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    case (op)
      4'd0: return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      4'd1: return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return 32'((64'(a) * (64'd1 << sh)) % 64'h1_0000_0000);
      4'd6: return 32'(64'(a) / (64'd1 << sh));
      4'd7: begin
        // floor division by 2^sh equals arithmetic right shift
        if (sa >= 0) return 32'(sa / (longint'(1) << sh));
        return 32'(-((-sa + (longint'(1) << sh) - 1) / (longint'(1) << sh)));
      end
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic m_ill(logic [3:0] op);
    return op >= 4'd10;
  endfunction

`ifdef ALU_FLAGS_EN
  function automatic logic m_carry(logic [3:0] op,
                                   logic [31:0] a, logic [31:0] b);
    if (op == 4'd0) return (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
    if (op == 4'd1) return a >= b;
    return 1'b0;
  endfunction

  function automatic logic m_ovf(logic [3:0] op,
                                 logic [31:0] a, logic [31:0] b);
    longint s;
    if (op == 4'd0) s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd1) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction
`endif

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard for the registered outputs.
  logic [31:0] e_res_q;
  logic        e_zero_q, e_ill_q;
`ifdef ALU_FLAGS_EN
  logic e_c_q, e_v_q, e_n_q;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e_res_q  <= 32'd0;
      e_zero_q <= 1'b1;
      e_ill_q  <= 1'b0;
`ifdef ALU_FLAGS_EN
      e_c_q <= 1'b0; e_v_q <= 1'b0; e_n_q <= 1'b0;
`endif
    end else if (en) begin
      e_res_q  <= m_res(alu_op, src_a, src_b);
      e_zero_q <= (m_res(alu_op, src_a, src_b) == 32'd0);
      e_ill_q  <= m_ill(alu_op);
`ifdef ALU_FLAGS_EN
      e_c_q <= m_carry(alu_op, src_a, src_b);
      e_v_q <= m_ovf(alu_op, src_a, src_b);
      e_n_q <= m_res(alu_op, src_a, src_b) >> 31;
`endif
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic [31:0] r;
      r = m_res(alu_op, src_a, src_b);
      chk("result", result, r);
      chk("zero", 32'(zero), 32'(r == 32'd0));
      chk("illegal_op", 32'(illegal_op), 32'(m_ill(alu_op)));
      chk("result_q", result_q, e_res_q);
      chk("zero_q", 32'(zero_q), 32'(e_zero_q));
      chk("illegal_q", 32'(illegal_q), 32'(e_ill_q));
`ifdef ALU_FLAGS_EN
      chk("carry", 32'(carry), 32'(m_carry(alu_op, src_a, src_b)));
      chk("overflow", 32'(overflow), 32'(m_ovf(alu_op, src_a, src_b)));
      chk("negative", 32'(negative), 32'(r[31]));
      chk("carry_q", 32'(carry_q), 32'(e_c_q));
      chk("overflow_q", 32'(overflow_q), 32'(e_v_q));
      chk("negative_q", 32'(negative_q), 32'(e_n_q));
`endif
    end
  end

  task automatic dir(string nm, logic [3:0] op, logic [31:0] a,
                     logic [31:0] b, logic [31:0] er, logic ez, logic ei);
    alu_op = op; src_a = a; src_b = b;
    #1;
    chk({nm, ".res"}, result, er);
    chk({nm, ".zero"}, 32'(zero), 32'(ez));
    chk({nm, ".ill"}, 32'(illegal_op), 32'(ei));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    src_a = '0; src_b = '0; alu_op = 4'd0;
    #1;
    chk("rst.result_q", result_q, 32'd0);
    chk("rst.zero_q", 32'(zero_q), 32'd1);
    chk("rst.illegal_q", 32'(illegal_q), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    chk_on = 1'b1;

    dir("add53",  4'd0, 32'd5, 32'd3, 32'd8, 1'b0, 1'b0);
    dir("addwrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0);
`ifdef ALU_FLAGS_EN
    chk("addwrap.carry", 32'(carry), 32'd1);
`endif
    dir("sub53",  4'd1, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0);
`ifdef ALU_FLAGS_EN
    dir("subovf", 4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b0);
    chk("subovf.overflow", 32'(overflow), 32'd1);
`endif
    dir("and",    4'd2, 32'hF, 32'hA, 32'hA, 1'b0, 1'b0);
    dir("or",     4'd3, 32'hF, 32'hA, 32'hF, 1'b0, 1'b0);
    dir("xor",    4'd4, 32'hF, 32'hA, 32'h5, 1'b0, 1'b0);
    dir("sll",    4'd5, 32'd1, 32'd2, 32'd4, 1'b0, 1'b0);
    dir("srl",    4'd6, 32'h8000_0000, 32'd1, 32'h4000_0000, 1'b0, 1'b0);
    dir("sra",    4'd7, 32'h8000_0000, 32'd1, 32'hC000_0000, 1'b0, 1'b0);
    dir("srlhi",  4'd6, 32'h8000_0000, 32'hFFFF_FFE1, 32'h4000_0000, 1'b0, 1'b0);
    dir("sll0",   4'd5, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0, 1'b0);
    dir("sra31",  4'd7, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    dir("slt",    4'd8, 32'hFFFF_FFFE, 32'd1, 32'd1, 1'b0, 1'b0);
    dir("sltu",   4'd9, 32'hFFFF_FFFE, 32'd1, 32'd0, 1'b1, 1'b0);
    dir("sltu12", 4'd9, 32'd1, 32'd2, 32'd1, 1'b0, 1'b0);
    dir("ill",    4'd15, 32'd5, 32'd3, 32'd0, 1'b1, 1'b1);

    // Reset values must persist until the first enabled edge.
    @(posedge clk); #1;
    chk("hold_rst.result_q", result_q, 32'd0);
    chk("hold_rst.zero_q", 32'(zero_q), 32'd1);

    #1;
    alu_op = 4'd0; src_a = 32'd5; src_b = 32'd3; en = 1'b1;
    @(posedge clk); #1;
    chk("reg.add", result_q, 32'd8);
    chk("reg.zero", 32'(zero_q), 32'd0);
    #1;
    en = 1'b0; src_a = 32'd7; src_b = 32'd7; alu_op = 4'd1;
    @(posedge clk); #1;
    chk("reg.hold", result_q, 32'd8);
    #1;
    rst = 1'b1;
    #1;
    chk("reg.rst_res", result_q, 32'd0);
    chk("reg.rst_zero", 32'(zero_q), 32'd1);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      alu_op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: begin src_a = $urandom; src_b = src_a; end
        1: begin src_a = $urandom_range(0, 40); src_b = $urandom_range(0, 40); end
        2: begin src_a = {1'b1, 31'($urandom)}; src_b = $urandom; end
        default: begin src_a = $urandom; src_b = $urandom; end
      endcase
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        #1 rst = 1'b1;
        #1;
        chk("rnd.rst_res", result_q, 32'd0);
        chk("rnd.rst_zero", 32'(zero_q), 32'd1);
        rst = 1'b0;
      end
    end

    @(posedge clk); #1;
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
